operand_issue: RTL
==================

# operand_issue

Execute-entry pipeline stage that registers one decoded instruction and presents its operands to the ALU. It selects the operand sources (register, PC, immediate, constant) and resolves RAW hazards by forwarding from the instruction currently in the ALU and from the memory stage. A load-use hazard inserts a one-cycle bubble. It sits between decode/register-read and the ALU, and its registered outputs drive the ALU `a`, `b` and `alu_op` inputs directly.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `REG_ADDR_WIDTH`, 5, register index width
- `clk`  in  1  the single clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid` / `in_ready`  in / out  1  decode-side handshake
- `in_pc`, `in_imm`, `in_rs1_data`, `in_rs2_data`  in  DATA_WIDTH  decoded PC, immediate, register-file read data
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  REG_ADDR_WIDTH  source and destination indices
- `in_rs1_used`, `in_rs2_used`  in  1  source actually read by the instruction
- `in_alu_op`  in  5  ALU opcode from the shared package
- `in_a_sel`, `in_b_sel`  in  2  operand selects (`a_sel_t` / `b_sel_t`)
- `in_reg_write`, `in_mem_read`, `in_mem_write`  in  1  control bits
- `alu_result`  in  DATA_WIDTH  combinational result of the instruction currently held here
- `mem_valid`, `mem_reg_write`  in  1  memory-stage instruction state
- `mem_rd`  in  REG_ADDR_WIDTH  memory-stage destination
- `mem_result`  in  DATA_WIDTH  memory-stage write-back value (load data or ALU result)
- `flush`  in  1  branch/trap kill
- `out_valid` / `out_ready`  out / in  1  ALU-side handshake
- `out_a`, `out_b`, `out_store_data`, `out_pc`  out  DATA_WIDTH  ALU operands, forwarded rs2, PC
- `out_alu_op`  out  5  registered opcode
- `out_rd`  out  REG_ADDR_WIDTH  registered destination
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1  registered control bits

## Operation
- `a_sel_t` values:
  - `A_RS1` selects forwarded rs1.
  - `A_PC` selects `in_pc`.
  - `A_ZERO` selects 0.
- `b_sel_t` values:
  - `B_RS2` selects forwarded rs2.
  - `B_IMM` selects `in_imm`.
  - `B_FOUR` selects 4.
  - The remaining encoding selects 0.
- Forwarded value for source `rsN`, highest priority first:
  - If `rsN == 0`: the value is 0, never forwarded.
  - If `out_valid && out_reg_write && out_rd == rsN`: the value is `alu_result`.
  - If `mem_valid && mem_reg_write && mem_rd == rsN`: the value is `mem_result`.
  - Otherwise: `in_rsN_data`. The register file is write-first, so write-back needs no bypass here.
- `out_store_data` is always forwarded rs2, regardless of `in_b_sel`.
- Load-use hazard: `hazard = in_valid && out_valid && out_mem_read && out_reg_write && out_rd != 0 && ((in_rs1_used && in_rs1_addr == out_rd) || (in_rs2_used && in_rs2_addr == out_rd))`.
- Ready: `in_ready = (!out_valid || out_ready) && !hazard && !flush`.
- Register update each cycle, first matching rule wins:
  - If `flush`: `out_valid <= 0`. Any incoming instruction is dropped.
  - Else if `in_valid && in_ready`: capture all outputs; `out_valid <= 1`.
  - Else if `out_ready`: `out_valid <= 0`. This is the bubble on hazard or empty input.
  - Otherwise: hold all outputs.
- When `out_valid == 0`, data outputs hold their last value. Downstream must qualify every output with `out_valid`.

## Timing
- Latency is one cycle from accepted input to `out_valid`. Throughput is one instruction per cycle with no hazard.
- A load-use hazard costs exactly one bubble. On the following cycle the load sits in the memory stage and its data comes through `mem_result`.
- `out_ready == 0` holds every output stable and forces `in_ready = 0`.
- Reset:
  - Asserting `rst_n` low drives all outputs to 0 immediately, including mid-operation.
  - `out_alu_op` resets to `ALU_ADD`.
  - The first capture can occur on the first rising edge after `rst_n` deasserts.
- `flush` together with a hazard or backpressure: `flush` wins and `out_valid` is 0 on the next cycle.

## Structure
- `isa_shared` holds:
  - `a_sel_t` and `b_sel_t` enums;
  - the `ALU_*` codes;
  - the constant `REG_ZERO = 0`.
- Sub-module `fwd_mux`: one source-forwarding priority mux, instantiated twice (rs1 and rs2). Hazard detection and the output register stay in `operand_issue`.

## Test plan
- Reset: hold `rst_n` low while `out_valid = 1` -> all outputs 0 at once, `out_alu_op = ALU_ADD`, `in_ready = 1` after release.
- Back-to-back dependency: ADD x1 = 5 + 7, then ADD x2 = x1 + x1 with `alu_result = 12` -> `out_a = 12`, `out_b = 12`, no stall.
- Load-use: LW x3, then ADDI x4 = x3 + 1 -> `in_ready = 0` for one cycle and one bubble. Then with `mem_rd = 3`, `mem_result = 0xDEAD` -> `out_a = 0xDEAD`, `out_b = 1`.
- Priority and x0:
  - ALU stage and memory stage both write x5 (`alu_result = 0x11`, `mem_result = 0x22`) -> `out_a = 0x11`.
  - A source of x0 with `out_rd = 0` -> `out_a = 0`.
- Flush: `flush` asserted in the same cycle as `in_valid` -> `in_ready = 0`, `out_valid = 0` next cycle, instruction lost.
- Backpressure: `out_ready = 0` for 3 cycles with `in_valid = 1` -> outputs stable, `in_ready = 0`. Capture occurs the cycle after `out_ready` rises.

Source files
------------

// File: rtl/isa_shared_pkg.sv
// Shared ISA encodings used by decode, operand issue and the ALU.
package isa_shared;

  localparam int unsigned REG_ZERO = 0;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2,
    B_ZERO = 2'd3
  } b_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding mux for one source operand: x0, ALU stage, memory stage, register file.
module fwd_mux
  import isa_shared::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [DATA_WIDTH-1:0]     i_rf_data,
  input  logic                      i_ex_fwd,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
  input  logic [DATA_WIDTH-1:0]     i_ex_result,
  input  logic                      i_mem_fwd,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
  input  logic [DATA_WIDTH-1:0]     i_mem_result,
  output logic [DATA_WIDTH-1:0]     o_data
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

  always_comb begin
    o_data = i_rf_data;
    if (i_rs_addr == ZERO_ADDR) begin
      o_data = '0;
    end else if (i_ex_fwd && (i_ex_rd == i_rs_addr)) begin
      o_data = i_ex_result;
    end else if (i_mem_fwd && (i_mem_rd == i_rs_addr)) begin
      o_data = i_mem_result;
    end
  end

endmodule

// File: rtl/operand_issue.sv
// Execute-entry stage: registers one decoded instruction, selects/forwards ALU operands and
// stalls one cycle on a load-use hazard.
module operand_issue
  import isa_shared::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [DATA_WIDTH-1:0]     i_in_pc,
  input  logic [DATA_WIDTH-1:0]     i_in_imm,
  input  logic [DATA_WIDTH-1:0]     i_in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     i_in_rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_in_rd_addr,
  input  logic                      i_in_rs1_used,
  input  logic                      i_in_rs2_used,
  input  logic [4:0]                i_in_alu_op,
  input  a_sel_t                    i_in_a_sel,
  input  b_sel_t                    i_in_b_sel,
  input  logic                      i_in_reg_write,
  input  logic                      i_in_mem_read,
  input  logic                      i_in_mem_write,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic                      i_mem_valid,
  input  logic                      i_mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
  input  logic [DATA_WIDTH-1:0]     i_mem_result,
  input  logic                      i_flush,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DATA_WIDTH-1:0]     o_out_a,
  output logic [DATA_WIDTH-1:0]     o_out_b,
  output logic [DATA_WIDTH-1:0]     o_out_store_data,
  output logic [DATA_WIDTH-1:0]     o_out_pc,
  output logic [4:0]                o_out_alu_op,
  output logic [REG_ADDR_WIDTH-1:0] o_out_rd,
  output logic                      o_out_reg_write,
  output logic                      o_out_mem_read,
  output logic                      o_out_mem_write
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_a, r_b, r_store_data, r_pc;
  logic [4:0]                r_alu_op;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_reg_write, r_mem_read, r_mem_write;

  logic                      w_ex_fwd, w_mem_fwd, w_hazard, w_accept;
  logic [DATA_WIDTH-1:0]     w_rs1_fwd, w_rs2_fwd, w_a, w_b;

  assign w_ex_fwd  = r_valid && r_reg_write;
  assign w_mem_fwd = i_mem_valid && i_mem_reg_write;

  fwd_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .i_rs_addr   (i_in_rs1_addr),
    .i_rf_data   (i_in_rs1_data),
    .i_ex_fwd    (w_ex_fwd),
    .i_ex_rd     (r_rd),
    .i_ex_result (i_alu_result),
    .i_mem_fwd   (w_mem_fwd),
    .i_mem_rd    (i_mem_rd),
    .i_mem_result(i_mem_result),
    .o_data      (w_rs1_fwd)
  );

  fwd_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .i_rs_addr   (i_in_rs2_addr),
    .i_rf_data   (i_in_rs2_data),
    .i_ex_fwd    (w_ex_fwd),
    .i_ex_rd     (r_rd),
    .i_ex_result (i_alu_result),
    .i_mem_fwd   (w_mem_fwd),
    .i_mem_rd    (i_mem_rd),
    .i_mem_result(i_mem_result),
    .o_data      (w_rs2_fwd)
  );

  always_comb begin
    w_a = '0;
    unique case (i_in_a_sel)
      A_RS1:   w_a = w_rs1_fwd;
      A_PC:    w_a = i_in_pc;
      default: w_a = '0;
    endcase
  end

  always_comb begin
    w_b = '0;
    unique case (i_in_b_sel)
      B_RS2:   w_b = w_rs2_fwd;
      B_IMM:   w_b = i_in_imm;
      B_FOUR:  w_b = DATA_WIDTH'(4);
      default: w_b = '0;
    endcase
  end

  // A load in the ALU stage has no data yet; the consumer must wait until it reaches memory.
  assign w_hazard = i_in_valid && r_valid && r_mem_read && r_reg_write && (r_rd != ZERO_ADDR) &&
                    ((i_in_rs1_used && (i_in_rs1_addr == r_rd)) ||
                     (i_in_rs2_used && (i_in_rs2_addr == r_rd)));

  assign o_in_ready = (!r_valid || i_out_ready) && !w_hazard && !i_flush;
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_pc         <= '0;
      r_alu_op     <= ALU_ADD;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_a          <= w_a;
      r_b          <= w_b;
      r_store_data <= w_rs2_fwd;
      r_pc         <= i_in_pc;
      r_alu_op     <= i_in_alu_op;
      r_rd         <= i_in_rd_addr;
      r_reg_write  <= i_in_reg_write;
      r_mem_read   <= i_in_mem_read;
      r_mem_write  <= i_in_mem_write;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_valid      = r_valid;
  assign o_out_a          = r_a;
  assign o_out_b          = r_b;
  assign o_out_store_data = r_store_data;
  assign o_out_pc         = r_pc;
  assign o_out_alu_op     = r_alu_op;
  assign o_out_rd         = r_rd;
  assign o_out_reg_write  = r_reg_write;
  assign o_out_mem_read   = r_mem_read;
  assign o_out_mem_write  = r_mem_write;

endmodule
